i2c_slave_rx_ctrl: RTL and testbench

Byte-level receive controller for the I2C slave datapath. It sequences the serial-to-parallel receive shift register by gating its shift enable per bit. It checks the address byte against a fixed slave address and drives the ACK/NACK bit. Received data bytes are handed to the RX FIFO with a one-cycle push strobe. It sits between the SCL/SDA edge and start/stop detectors, the receive shift register, the SDA output mux and the RX FIFO. It supports master-write transfers only; reads are NACKed.

---
 rtl/i2c_slave_rx_ctrl_if.sv | 28 ++
 rtl/i2c_slave_rx_ctrl.sv | 120 ++++++++++++
 tb/tb_i2c_slave_rx_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_rx_ctrl_if.sv
// rtl/i2c_slave_rx_ctrl_if.sv - detector, shift register and FIFO signals of the I2C slave receive controller
interface i2c_slave_rx_ctrl_if;
  logic       start_found;
  logic       stop_found;
  logic       rising_edge_found;
  logic       falling_edge_found;
  logic [7:0] rx_data;
  logic       fifo_full;
  logic       rx_enable;
  logic       sda_ack;
  logic       rx_push;
  logic       busy;
  logic       nack_err;

  // Bus side: detectors, shift register and FIFO drive the inputs
  modport master (
    output start_found, stop_found, rising_edge_found, falling_edge_found,
    output rx_data, fifo_full,
    input  rx_enable, sda_ack, rx_push, busy, nack_err
  );

  // Controller side
  modport slave (
    input  start_found, stop_found, rising_edge_found, falling_edge_found,
    input  rx_data, fifo_full,
    output rx_enable, sda_ack, rx_push, busy, nack_err
  );
endinterface

// File: rtl/i2c_slave_rx_ctrl.sv
// rtl/i2c_slave_rx_ctrl.sv - byte-level receive controller for the I2C slave (master-write only)
module i2c_slave_rx_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1E
) (
  input  logic               clk,
  input  logic               rst,
  i2c_slave_rx_ctrl_if.slave bus_if
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_DATA, ST_ACK_D, ST_NACK, ST_IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       push_evt, nack_evt;
  logic       counting;
  logic       addr_hit;
  logic       rx_enable_q, rx_enable_d;
  logic       sda_ack_q, sda_ack_d;
  logic       rx_push_q, rx_push_d;
  logic       busy_q, busy_d;
  logic       nack_err_q, nack_err_d;

  // Only a write to our own address is accepted; reads fall into IGNORE
  assign addr_hit = (bus_if.rx_data[7:1] == SLAVE_ADDR) && !bus_if.rx_data[0];
  assign counting = (state_q == ST_ADDR) || (state_q == ST_ACK_A) || (state_q == ST_DATA) ||
                    (state_q == ST_ACK_D) || (state_q == ST_NACK);

  // State, bit counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      rx_enable_q <= 1'b0;
      sda_ack_q   <= 1'b0;
      rx_push_q   <= 1'b0;
      busy_q      <= 1'b0;
      nack_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_enable_q <= rx_enable_d;
      sda_ack_q   <= sda_ack_d;
      rx_push_q   <= rx_push_d;
      busy_q      <= busy_d;
      nack_err_q  <= nack_err_d;
    end
  end

  // Next state: start beats stop beats SCL edges; byte boundaries act on the falling edge
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    push_evt  = 1'b0;
    nack_evt  = 1'b0;
    if (bus_if.start_found) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
    end else if (bus_if.stop_found) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
    end else begin
      if (bus_if.rising_edge_found && counting && (bit_cnt_q != 4'd8)) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      case (state_q)
        ST_ADDR: begin
          if (bus_if.falling_edge_found && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = 4'd0;
            state_d   = addr_hit ? ST_ACK_A : ST_IGNORE;
          end
        end
        ST_ACK_A, ST_ACK_D: begin
          if (bus_if.falling_edge_found && (bit_cnt_q == 4'd1)) begin
            bit_cnt_d = 4'd0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus_if.falling_edge_found && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = 4'd0;
            if (bus_if.fifo_full) begin
              nack_evt = 1'b1;
              state_d  = ST_NACK;
            end else begin
              push_evt = 1'b1;
              state_d  = ST_ACK_D;
            end
          end
        end
        ST_NACK: begin
          if (bus_if.falling_edge_found && (bit_cnt_q == 4'd1)) begin
            bit_cnt_d = 4'd0;
            state_d   = ST_IGNORE;
          end
        end
        default: begin
          bit_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change together with it
  always_comb begin
    rx_enable_d = (state_d == ST_ADDR) || (state_d == ST_DATA);
    sda_ack_d   = (state_d == ST_ACK_A) || (state_d == ST_ACK_D);
    busy_d      = (state_d != ST_IDLE);
    rx_push_d   = push_evt;
    nack_err_d  = nack_evt;
  end

  assign bus_if.rx_enable = rx_enable_q;
  assign bus_if.sda_ack   = sda_ack_q;
  assign bus_if.rx_push   = rx_push_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.nack_err  = nack_err_q;

endmodule

// File: tb/tb_i2c_slave_rx_ctrl.sv
// tb/tb_i2c_slave_rx_ctrl.sv - scoreboard bench for the I2C slave receive controller
module tb_i2c_slave_rx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sda_bit = 1'b0;
  logic sda_q = 1'b0;
  logic rise_q = 1'b0;
  logic [7:0] sr = 8'h00;
  int tests = 0;
  int fails = 0;
  logic [8:0] sb[$];

  i2c_slave_rx_ctrl_if bus();

  i2c_slave_rx_ctrl dut (.clk(clk), .rst(rst), .bus_if(bus));

  always #5 clk = ~clk;

  assign bus.rx_data = sr;

  // Receive shift register: latches SDA on a delayed SCL rise while enabled
  always @(posedge clk) begin
    rise_q <= bus.rising_edge_found;
    sda_q  <= sda_bit;
    if (rise_q && bus.rx_enable) sr <= {sr[6:0], sda_q};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every push or nack pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (!rst && (bus.rx_push || bus.nack_err)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got push=%0b nack=%0b data=%0h expected none",
                 bus.rx_push, bus.nack_err, bus.rx_data);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("sb_event", {23'd0, bus.nack_err, (bus.rx_push ? bus.rx_data : 8'h00)}, {23'd0, e});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rise();
    bus.rising_edge_found = 1'b1; tick(1); bus.rising_edge_found = 1'b0;
  endtask

  task automatic pulse_fall();
    bus.falling_edge_found = 1'b1; tick(1); bus.falling_edge_found = 1'b0;
  endtask

  task automatic send_start();
    bus.start_found = 1'b1; tick(1); bus.start_found = 1'b0;
    tick(2);
  endtask

  task automatic send_stop();
    bus.stop_found = 1'b1; tick(1); bus.stop_found = 1'b0;
    @(negedge clk);
    chk("stop_busy", bus.busy, 0);
    chk("stop_rx_enable", bus.rx_enable, 0);
    chk("stop_sda_ack", bus.sda_ack, 0);
    tick(3);
  endtask

  task automatic send_bit(input logic b, input logic full_at_fall);
    sda_bit = b;
    tick(2);
    pulse_rise();
    tick(3);
    bus.fifo_full = full_at_fall;
    pulse_fall();
    bus.fifo_full = 1'($urandom_range(0, 1));
  endtask

  // Eight data bits; fifo_full is noise except on the byte-complete falling edge
  task automatic send_bits8(input logic [7:0] b, input logic full, input logic exp_en);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        @(negedge clk);
        chk("bit_rx_enable", bus.rx_enable, exp_en);
        chk("bit_sda_ack", bus.sda_ack, 0);
        chk("bit_busy", bus.busy, 1);
        tick(1);
      end
      send_bit(b[i], (i == 0) ? full : 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic ack_slot(input logic exp_ack);
    @(negedge clk);
    chk("ack_after_8th_fall", bus.sda_ack, exp_ack);
    chk("ack_rx_enable", bus.rx_enable, 0);
    tick(1);
    sda_bit = 1'($urandom_range(0, 1));
    tick(1);
    pulse_rise();
    tick(3);
    @(negedge clk);
    chk("ack_during_9th", bus.sda_ack, exp_ack);
    tick(1);
    pulse_fall();
    @(negedge clk);
    chk("ack_after_9th_fall", bus.sda_ack, 0);
    tick(1);
  endtask

  // Reference model: only a write to 0x1E is served; a full FIFO NACKs and ends the transfer
  task automatic run_txn(input logic [7:0] addr, input int n, input logic [7:0] d[4], input logic f[4]);
    logic active;
    active = (addr == 8'h3C);
    send_start();
    send_bits8(addr, 1'b0, 1'b1);
    ack_slot(active);
    for (int k = 0; k < n; k++) begin
      logic en;
      logic ack;
      en  = active;
      ack = active && !f[k];
      if (active) begin
        if (f[k]) begin
          sb.push_back({1'b1, 8'h00});
          active = 1'b0;
        end else begin
          sb.push_back({1'b0, d[k]});
        end
      end
      send_bits8(d[k], f[k], en);
      ack_slot(ack);
    end
    send_stop();
  endtask

  initial begin
    logic [7:0] d[4];
    logic       f[4];
    logic [7:0] a;
    int         n;
    bus.start_found = 1'b0;
    bus.stop_found = 1'b0;
    bus.rising_edge_found = 1'b0;
    bus.falling_edge_found = 1'b0;
    bus.fifo_full = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rx_enable", bus.rx_enable, 0);
    chk("rst_sda_ack", bus.sda_ack, 0);
    chk("rst_rx_push", bus.rx_push, 0);
    chk("rst_nack_err", bus.nack_err, 0);
    rst = 1'b0;
    tick(2);

    // Directed transfers: two accepted bytes, read, miss, FIFO full
    d = '{8'hA5, 8'h5A, 8'h00, 8'h00}; f = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_txn(8'h3C, 2, d, f);
    run_txn(8'h3D, 1, d, f);
    run_txn(8'h40, 2, d, f);
    d = '{8'hFF, 8'h77, 8'h00, 8'h00}; f = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_txn(8'h3C, 2, d, f);

    // Repeated START after four data bits, then a normal byte
    send_start();
    send_bits8(8'h3C, 1'b0, 1'b1);
    ack_slot(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    send_start();
    @(negedge clk);
    chk("rs_rx_enable", bus.rx_enable, 1);
    chk("rs_busy", bus.busy, 1);
    tick(1);
    send_bits8(8'h3C, 1'b0, 1'b1);
    ack_slot(1'b1);
    sb.push_back({1'b0, 8'h11});
    send_bits8(8'h11, 1'b0, 1'b1);
    ack_slot(1'b1);

    // START and STOP together: START wins
    bus.start_found = 1'b1; bus.stop_found = 1'b1; tick(1);
    bus.start_found = 1'b0; bus.stop_found = 1'b0;
    @(negedge clk);
    chk("ss_rx_enable", bus.rx_enable, 1);
    chk("ss_busy", bus.busy, 1);
    tick(2);
    send_bits8(8'h3C, 1'b0, 1'b1);
    ack_slot(1'b1);
    send_stop();

    // Asynchronous reset while ACKing the address
    send_start();
    send_bits8(8'h3C, 1'b0, 1'b1);
    @(negedge clk);
    chk("pre_rst_ack", bus.sda_ack, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_sda_ack", bus.sda_ack, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_rx_enable", bus.rx_enable, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    pulse_rise();
    tick(3);
    pulse_fall();
    @(negedge clk);
    chk("post_rst_idle_busy", bus.busy, 0);
    chk("post_rst_idle_ack", bus.sda_ack, 0);
    tick(1);

    // Randomized transfers
    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 3))
        0, 1: a = 8'h3C;
        2: a = 8'h3D;
        default: a = 8'($urandom_range(0, 255));
      endcase
      n = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) begin
        d[k] = 8'($urandom_range(0, 255));
        f[k] = ($urandom_range(0, 3) == 0);
      end
      run_txn(a, n, d, f);
    end

    tick(4);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
